// File: rtl/axis_pkt_loopback_sf_if.sv
// AXI4-Stream bundle shared by the receive and transmit sides of the loopback.
// The master drives the beat fields; the slave drives tready back.
interface axis_pkt_loopback_sf_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic                tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pkt_loopback_sf.sv
// Store-and-forward Ethernet loopback: buffers whole frames, drops bad, runt and
// overflowing frames, and optionally swaps destination/source MAC on the way out.
module axis_pkt_loopback_sf #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 512,
  parameter int SWAP_EN = 1
) (
  input  logic                          axis_clk,
  input  logic                          axis_reset,
  input  logic                          l2_addr_swap_en,
  axis_pkt_loopback_sf_if.slave         s_axis,
  axis_pkt_loopback_sf_if.master        m_axis,
  output logic [15:0]                   frames_fwd,
  output logic [15:0]                   frames_drop,
  output logic                          overflow
);

  localparam int KEEP_W    = DATA_W / 8;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int HDR_WORDS = (96 + DATA_W - 1) / DATA_W;
  localparam int HDR_W     = HDR_WORDS * DATA_W;
  localparam int ENTRY_W   = DATA_W + KEEP_W + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
  localparam logic [1:0]    PF_LAST  = 2'(HDR_WORDS - 1);
  localparam logic [1:0]    HDR_CNT  = 2'(HDR_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DISCARD} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} rd_state_t;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr, cm_ptr, rd_ptr;

  // ---------------------------------------------------------------- write side
  wr_state_t   wr_state, wr_next;
  logic        rx_ready, beat, full;
  logic [4:0]  keep_cnt, len_q, prior_len, len_sum;
  logic        long_enough;
  logic        wr_en, do_commit, do_rollback, inc_fwd, inc_drop, set_ovf;

  assign s_axis.tready = rx_ready;
  assign beat          = s_axis.tvalid && rx_ready;
  // Occupancy against the registered read pointer: a same-cycle read is not credited.
  assign full          = (wr_ptr - rd_ptr) == PTR_FULL;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) keep_cnt += {4'd0, s_axis.tkeep[i]};
  end

  assign prior_len   = (wr_state == W_FRAME) ? len_q : 5'd0;
  assign len_sum     = prior_len + keep_cnt;
  assign long_enough = len_sum >= 5'd12;

  // NOTE: every output of a combinational process gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    wr_next     = wr_state;
    wr_en       = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    inc_fwd     = 1'b0;
    inc_drop    = 1'b0;
    set_ovf     = 1'b0;
    if (beat) begin
      case (wr_state)
        W_IDLE, W_FRAME: begin
          if (full) begin
            do_rollback = 1'b1;
            set_ovf     = 1'b1;
            if (s_axis.tlast) begin
              inc_drop = 1'b1;
              wr_next  = W_IDLE;
            end else begin
              wr_next  = W_DISCARD;
            end
          end else begin
            wr_en = 1'b1;
            if (s_axis.tlast) begin
              wr_next = W_IDLE;
              if (!s_axis.tuser && long_enough) begin
                do_commit = 1'b1;
                inc_fwd   = 1'b1;
              end else begin
                do_rollback = 1'b1;
                inc_drop    = 1'b1;
              end
            end else begin
              wr_next = W_FRAME;
            end
          end
        end
        W_DISCARD: begin
          if (s_axis.tlast) begin
            inc_drop = 1'b1;
            wr_next  = W_IDLE;
          end
        end
        default: wr_next = W_IDLE;
      endcase
    end
  end

  // NOTE: state and registers update with non-blocking assignments so every
  // process sees the same pre-edge values regardless of evaluation order.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      wr_state    <= W_IDLE;
      rx_ready    <= 1'b0;
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      len_q       <= '0;
      frames_fwd  <= '0;
      frames_drop <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_state <= wr_next;
      rx_ready <= 1'b1;
      if (beat) len_q <= (len_sum > 5'd16) ? 5'd16 : len_sum;
      if (do_rollback)  wr_ptr <= cm_ptr;
      else if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_commit)    cm_ptr <= wr_ptr + PTR_ONE;
      if (inc_fwd  && frames_fwd  != 16'hFFFF) frames_fwd  <= frames_fwd + 16'd1;
      if (inc_drop && frames_drop != 16'hFFFF) frames_drop <= frames_drop + 16'd1;
      if (set_ovf) overflow <= 1'b1;
    end
  end

  // NOTE: the frame store carries no reset; pointers alone define what is valid,
  // which lets the array map onto plain RAM.
  always_ff @(posedge axis_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  // ----------------------------------------------------------------- read side
  rd_state_t               rd_state, rd_next;
  logic [1:0]              pf_cnt, hdr_idx;
  logic [HDR_W-1:0]        hdr_data, hdr_sw;
  logic [HDR_WORDS*KEEP_W-1:0] hdr_keep;
  logic [3:0]              hdr_last;
  logic                    swap_q;
  logic                    eligible, out_ready, hdr_sel;
  logic                    pf_load, out_load, swap_sample;
  logic [DATA_W-1:0]       rd_data, cur_data;
  logic [KEEP_W-1:0]       rd_keep, cur_keep;
  logic                    rd_last, cur_last;
  logic                    tvalid_q, tlast_q;
  logic [DATA_W-1:0]       tdata_q;
  logic [KEEP_W-1:0]       tkeep_q;

  assign {rd_last, rd_keep, rd_data} = mem[rd_ptr[AW-1:0]];
  assign eligible  = rd_ptr != cm_ptr;
  assign out_ready = !tvalid_q || m_axis.tready;
  assign hdr_sel   = hdr_idx < HDR_CNT;

  always_comb begin
    hdr_sw = hdr_data;
    if (swap_q) begin
      for (int b = 0; b < 6; b++) begin
        hdr_sw[b*8 +: 8]     = hdr_data[(b+6)*8 +: 8];
        hdr_sw[(b+6)*8 +: 8] = hdr_data[b*8 +: 8];
      end
    end
  end

  assign cur_data = hdr_sel ? hdr_sw[hdr_idx*DATA_W +: DATA_W]   : rd_data;
  assign cur_keep = hdr_sel ? hdr_keep[hdr_idx*KEEP_W +: KEEP_W] : rd_keep;
  assign cur_last = hdr_sel ? hdr_last[hdr_idx]                  : rd_last;

  always_comb begin
    rd_next     = rd_state;
    pf_load     = 1'b0;
    out_load    = 1'b0;
    swap_sample = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (eligible) begin
          rd_next     = R_PREFETCH;
          swap_sample = 1'b1;
        end
      end
      R_PREFETCH: begin
        pf_load = 1'b1;
        if (pf_cnt == PF_LAST) rd_next = R_STREAM;
      end
      R_STREAM: begin
        if (out_ready) begin
          out_load = 1'b1;
          if (cur_last) rd_next = R_IDLE;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
      pf_cnt   <= '0;
      hdr_idx  <= '0;
      hdr_data <= '0;
      hdr_keep <= '0;
      hdr_last <= '0;
      swap_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
    end else begin
      rd_state <= rd_next;
      if (swap_sample) begin
        swap_q  <= (SWAP_EN != 0) && l2_addr_swap_en;
        pf_cnt  <= '0;
        hdr_idx <= '0;
      end
      if (pf_load) begin
        hdr_data[pf_cnt*DATA_W +: DATA_W] <= rd_data;
        hdr_keep[pf_cnt*KEEP_W +: KEEP_W] <= rd_keep;
        hdr_last[pf_cnt]                  <= rd_last;
        pf_cnt <= pf_cnt + 2'd1;
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (out_load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= cur_data;
        tkeep_q  <= cur_keep;
        tlast_q  <= cur_last;
        if (hdr_sel) hdr_idx <= hdr_idx + 2'd1;
        else         rd_ptr  <= rd_ptr + PTR_ONE;
      end else if (m_axis.tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = 1'b0;

endmodule

// File: tb/tb_axis_pkt_loopback_sf.sv
// Directed bench for the store-and-forward loopback: a table of single frames,
// then overflow, stalled back-to-back traffic and reset-during-output sequences.
module tb_axis_pkt_loopback_sf;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int KW     = DATA_W / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swap_en = 1'b0;
  logic [15:0] frames_fwd, frames_drop;
  logic        overflow;
  int          rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always #5 clk = ~clk;

  axis_pkt_loopback_sf_if #(.DATA_W(DATA_W)) s_if ();
  axis_pkt_loopback_sf_if #(.DATA_W(DATA_W)) m_if ();

  axis_pkt_loopback_sf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SWAP_EN(1)) dut (
    .axis_clk        (clk),
    .axis_reset      (rst),
    .l2_addr_swap_en (swap_en),
    .s_axis          (s_if.slave),
    .m_axis          (m_if.master),
    .frames_fwd      (frames_fwd),
    .frames_drop     (frames_drop),
    .overflow        (overflow)
  );

  always @(posedge clk) begin
    #1;
    m_if.tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Output monitor: collects transferred bytes and notes any change while stalled.
  logic [7:0]        out_bytes[$];
  int                out_frames = 0, cur_beats = 0, last_beats = 0, stall_viol = 0, tuser_viol = 0;
  logic [KW-1:0]     last_keep = '0;
  logic              prev_stall = 1'b0, prev_last = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [KW-1:0]     prev_keep = '0;

  always @(negedge clk) begin
    if (rst) begin
      cur_beats  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data ||
                         m_if.tkeep !== prev_keep || m_if.tlast !== prev_last))
        stall_viol++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_keep  = m_if.tkeep;
      prev_last  = m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        if (m_if.tuser !== 1'b0) tuser_viol++;
        for (int j = 0; j < KW; j++)
          if (m_if.tkeep[j]) out_bytes.push_back(m_if.tdata[j*8 +: 8]);
        cur_beats++;
        if (m_if.tlast) begin
          out_frames++;
          last_beats = cur_beats;
          last_keep  = m_if.tkeep;
          cur_beats  = 0;
        end
      end
    end
  end

  int         checks = 0, errors = 0;
  logic [7:0] exp_bytes[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send_frame(input int len, input int start, input bit bad);
    int nb = (len + KW - 1) / KW;
    logic [DATA_W-1:0] d;
    logic [KW-1:0]     k;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < KW; j++) begin
        if (b*KW + j < len) begin
          d[j*8 +: 8] = 8'(start + b*KW + j);
          k[j]        = 1'b1;
        end
      end
      @(posedge clk); #1;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tlast  = (b == nb - 1);
      s_if.tuser  = bad && (b == nb - 1);
    end
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic push_exp(input int len, input int start, input bit sw);
    int src;
    for (int i = 0; i < len; i++) begin
      src = i;
      if (sw && i < 12) src = (i < 6) ? i + 6 : i - 6;
      exp_bytes.push_back(8'(start + src));
    end
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n = 0;
    while (out_frames < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(out_frames >= target), 64'd1);
  endtask

  task automatic compare_out(input string name, input int base);
    check({name, "_len"}, 64'(out_bytes.size() - base), 64'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && base + i < out_bytes.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 64'(out_bytes[base + i]), 64'(exp_bytes[i]));
  endtask

  typedef struct {
    int len;
    int start;
    bit bad;
    bit swap;
    bit pass;
    int fwd;
    int drop;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base, fb, n;

    vecs[0] = '{64, 'h00, 0, 0, 1, 1, 0};  // plain 64-byte frame
    vecs[1] = '{64, 'h00, 0, 1, 1, 2, 0};  // MAC swap
    vecs[2] = '{60, 'h80, 1, 0, 0, 2, 1};  // tuser error on tlast
    vecs[3] = '{64, 'h40, 0, 0, 1, 3, 1};  // good frame after the bad one
    vecs[4] = '{ 8, 'h10, 0, 0, 0, 3, 2};  // runt, single beat
    vecs[5] = '{12, 'h20, 0, 0, 1, 4, 2};  // shortest legal frame
    vecs[6] = '{11, 'h30, 0, 0, 0, 4, 3};  // one byte short
    vecs[7] = '{13, 'h90, 0, 1, 1, 5, 3};  // swap on a short frame

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;

    #2;
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
    check("rst_m_tkeep",  64'(m_if.tkeep),  64'd0);
    check("rst_m_tlast",  64'(m_if.tlast),  64'd0);
    check("rst_counters", {32'd0, frames_fwd, frames_drop}, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("tready_before_edge", 64'(s_if.tready), 64'd0);
    @(posedge clk); #1;
    check("tready_after_edge", 64'(s_if.tready), 64'd1);

    foreach (vecs[v]) begin
      exp_bytes.delete();
      base    = out_bytes.size();
      fb      = out_frames;
      swap_en = vecs[v].swap;
      send_frame(vecs[v].len, vecs[v].start, vecs[v].bad);
      if (vecs[v].pass) begin
        push_exp(vecs[v].len, vecs[v].start, vecs[v].swap);
        wait_frames($sformatf("v%0d", v), fb + 1, 100);
      end
      repeat (20) @(posedge clk);
      check($sformatf("v%0d_frames", v), 64'(out_frames - fb), 64'(vecs[v].pass));
      compare_out($sformatf("v%0d", v), base);
      check($sformatf("v%0d_fwd", v),  64'(frames_fwd),  64'(vecs[v].fwd));
      check($sformatf("v%0d_drop", v), 64'(frames_drop), 64'(vecs[v].drop));
      if (v == 0) begin
        check("v0_beats",     64'(last_beats), 64'd8);
        check("v0_last_keep", 64'(last_keep),  64'hFF);
      end
    end
    swap_en = 1'b0;

    // Overflow: 80 beats into a 64-word store with the output held off.
    rdy_mode = 0;
    base = out_bytes.size();
    fb   = out_frames;
    send_frame(80 * KW, 'h00, 1'b0);
    repeat (10) @(posedge clk);
    check("ovf_flag", 64'(overflow),    64'd1);
    check("ovf_drop", 64'(frames_drop), 64'd4);
    check("ovf_fwd",  64'(frames_fwd),  64'd5);
    rdy_mode = 1;
    repeat (30) @(posedge clk);
    check("ovf_no_output", 64'(out_frames - fb), 64'd0);
    exp_bytes.delete();
    push_exp(64, 'h55, 1'b0);
    send_frame(64, 'h55, 1'b0);
    wait_frames("after_ovf", fb + 1, 100);
    compare_out("after_ovf", base);
    check("after_ovf_fwd", 64'(frames_fwd), 64'd6);

    // Three frames with random output back-pressure.
    rdy_mode = 2;
    exp_bytes.delete();
    base = out_bytes.size();
    fb   = out_frames;
    push_exp(64,  'h01, 1'b0);
    push_exp(100, 'h21, 1'b0);
    push_exp(37,  'hA0, 1'b0);
    send_frame(64,  'h01, 1'b0);
    send_frame(100, 'h21, 1'b0);
    send_frame(37,  'hA0, 1'b0);
    wait_frames("rand", fb + 3, 2000);
    compare_out("rand", base);
    check("rand_fwd",   64'(frames_fwd), 64'd9);
    check("stall_hold", 64'(stall_viol), 64'd0);
    check("tuser_zero", 64'(tuser_viol), 64'd0);

    // Reset while a frame is presented but stalled.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    base = out_bytes.size();
    fb   = out_frames;
    send_frame(64, 'h33, 1'b0);
    n = 0;
    while (m_if.tvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_tvalid_seen", 64'(m_if.tvalid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid",   64'(m_if.tvalid), 64'd0);
    check("mid_rst_tready",   64'(s_if.tready), 64'd0);
    check("mid_rst_counters", {32'd0, frames_fwd, frames_drop}, 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 1;
    repeat (40) @(posedge clk);
    check("mid_no_partial", 64'(out_bytes.size() - base), 64'd0);
    exp_bytes.delete();
    push_exp(12, 'hC0, 1'b0);
    send_frame(12, 'hC0, 1'b0);
    wait_frames("post_rst", fb + 1, 100);
    compare_out("post_rst", base);
    check("post_rst_fwd", 64'(frames_fwd), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
